nibble_serial_sub: RTL and testbench

NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

---
 rtl/nibble_serial_sub.sv | 142 ++++++++++++++
 tb/tb_nibble_serial_sub.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: A - B - Bin, one 4-bit lookahead nibble per cycle,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] na, nb, g, p, c, sum;
  logic       c4;

  // Low nibble of the shifting operands, lookahead carries
  always_comb begin
    na   = a_q[3:0];
    nb   = ~b_q[3:0];
    g    = na & nb;
    p    = na ^ nb;
    c[0] = ~brw_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = A;
          b_d     = B;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          brw_d   = Bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        acc_d = {sum, acc_q[WIDTH-1:4]};
        brw_d = ~c4;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          diff_d  = acc_d;
          bout_d  = ~c4;
          ovf_d   = (a_msb_q != b_msb_q) && (sum[3] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign Diff        = diff_q;
  assign Bout        = bout_q;
  assign Ovf         = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub: directed table, random ops against an
// arithmetic model, back-pressure and mid-operation reset sequences.
module tb_nibble_serial_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  nibble_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .Bin(Bin),
    .Diff(Diff), .Bout(Bout), .Ovf(Ovf),
    .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ediff;
    logic         ebout;
    logic         eovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference computed from integer arithmetic on the operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, output logic [W-1:0] d,
                       output logic bo, output logic ov);
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r  = ua - ub - int'(bin);
    d  = W'(r & 32'hFFFF);
    bo = (ua < ub + int'(bin));
    r  = sa - sb - int'(bin);
    ov = (r < -32768) || (r > 32767);
  endtask

  // Accept one op and wait for done; leaves DUT in DONE
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bin, input string name);
    int lat;
    @(negedge clk);
    check({name, "_sready"}, 32'(start_ready), 32'd1);
    A = a; B = b; Bin = bin; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    check({name, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic finish_op(input string name);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check({name, "_idle"}, 32'({start_ready, done_valid, busy}), 32'b100);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    start_and_wait(v.a, v.b, v.bin, name);
    check({name, "_diff"}, 32'(Diff), 32'(v.ediff));
    check({name, "_bout"}, 32'(Bout), 32'(v.ebout));
    check({name, "_ovf"}, 32'(Ovf), 32'(v.eovf));
    finish_op(name);
  endtask

  vec_t tbl[7];

  initial begin
    logic [W-1:0] md, hold_d;
    logic         mb, mo, hold_b, hold_o;
    bit           saw_done;

    tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    #3;
    check("reset_outs", 32'({start_ready, done_valid, busy, Bout, Ovf}),
          32'b10000);
    check("reset_diff", 32'(Diff), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Result retained in IDLE; stray done_ready ignored
    repeat (3) begin
      @(negedge clk);
      done_ready = 1'b1;
    end
    @(negedge clk);
    done_ready = 1'b0;
    check("retain_diff", 32'(Diff), 32'hFFFF);
    check("retain_flags", 32'({Bout, Ovf, start_ready, busy}), 32'b1010);

    for (int n = 0; n < 150; n++) begin
      vec_t v;
      v.a = W'($urandom);
      v.b = W'($urandom);
      if (n % 10 == 0) v.b = v.a;
      v.bin = 1'($urandom);
      model(v.a, v.b, v.bin, md, mb, mo);
      v.ediff = md; v.ebout = mb; v.eovf = mo;
      run_vec(v, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Back-pressure: hold result while upstream pokes
    start_and_wait(16'h4321, 16'h1234, 1'b0, "bp");
    hold_d = Diff; hold_b = Bout; hold_o = Ovf;
    check("bp_diff0", 32'(hold_d), 32'h30ED);
    for (int k = 0; k < 3; k++) begin
      start_valid = ~start_valid;
      A = W'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), 32'({Diff, Bout, Ovf}),
            32'({hold_d, hold_b, hold_o}));
      check($sformatf("bp_state%0d", k),
            32'({start_ready, done_valid}), 32'b01);
    end
    start_valid = 1'b0;
    finish_op("bp");

    // Reset while processing nibble 2
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_outs", 32'({start_ready, done_valid, busy, Bout, Ovf}),
          32'b10000);
    check("rst_diff", 32'(Diff), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_valid) saw_done = 1'b1;
    end
    check("rst_no_done", 32'(saw_done), 32'd0);
    run_vec('{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0}, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
